// File: rtl/step_ramp_gen.sv
// -----------------------------------------------------------------------------
// step_ramp_gen
//   Trapezoidal step-pulse generator feeding a stepper coil sequencer. A move
//   command (step count + direction) produces a PWM step train that starts at
//   START_PERIOD, shortens by ACCEL_DEC per step down to MIN_PERIOD, cruises,
//   then lengthens again so the final step is back at START_PERIOD. Short
//   moves produce a triangular profile and never cruise.
//
// Ports
//   CLK       in   1      system clock, rising edge
//   RST       in   1      synchronous active-high reset
//   START     in   1      move request, sampled only while idle
//   DIR_in    in   1      move direction, latched on an accepted START
//   STEPS     in   CNT_W  steps to issue, latched on an accepted START
//   ABORT     in   1      controlled stop request (only with STEP_ABORT_EN)
//   PWM       out  1      step pulse train, PULSE_W cycles high per step
//   DIR_out   out  1      latched direction, stable for the whole move
//   BUSY      out  1      high from accepted START until DONE
//   DONE      out  1      one-cycle pulse when the move completes
//   STEP_CNT  out  CNT_W  steps issued in the current or last move
//
// Configuration
//   STEP_ABORT_EN  when defined, adds the ABORT port. ABORT during ACCEL or
//                  CRUISE trims the remaining steps to what deceleration needs
//                  (ramp+1) so the move winds down and still ends with DONE.
// -----------------------------------------------------------------------------
module step_ramp_gen #(
    parameter int CNT_W        = 16,
    parameter int START_PERIOD = 1000,
    parameter int MIN_PERIOD   = 200,
    parameter int ACCEL_DEC    = 20,
    parameter int PULSE_W      = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DIR_in,
    input  logic [CNT_W-1:0] STEPS,
`ifdef STEP_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             PWM,
    output logic             DIR_out,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] STEP_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DEC_P   = CNT_W'(ACCEL_DEC);
    localparam logic [CNT_W-1:0] PULSE_P = CNT_W'(PULSE_W);
    // Thresholds checked before the period arithmetic so it never wraps or
    // overshoots: below SUB_FLOOR a decrement would pass MIN_PERIOD, above
    // ADD_CEIL an increment would pass START_PERIOD.
    localparam logic [CNT_W-1:0] SUB_FLOOR = CNT_W'(MIN_PERIOD + ACCEL_DEC);
    localparam logic [CNT_W-1:0] ADD_CEIL  = CNT_W'(START_PERIOD - ACCEL_DEC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] cur_period_q, cur_period_d;
    logic [CNT_W-1:0] ramp_q, ramp_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             pwm_q, pwm_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             abort_req;
    logic             period_end;
    logic             near_end;
    logic             run_d;
    logic [CNT_W:0]   ramp_ext;
    logic [CNT_W-1:0] rem_eff;
    logic [CNT_W-1:0] rem_new;
    logic [CNT_W-1:0] faster_period;

`ifdef STEP_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        cur_period_d = cur_period_q;
        ramp_d       = ramp_q;
        remaining_d  = remaining_q;
        step_cnt_d   = step_cnt_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        period_end    = (period_cnt_q == cur_period_q - ONE);
        ramp_ext      = {1'b0, ramp_q} + (CNT_W+1)'(1);
        faster_period = (cur_period_q < SUB_FLOOR) ? MIN_P : cur_period_q - DEC_P;

        // An abort only trims the step budget; the normal near-end test then
        // steers the move into DECEL at the next period end.
        rem_eff = remaining_q;
        if (abort_req && (state_q == S_ACCEL || state_q == S_CRUISE)
            && ({1'b0, remaining_q} > ramp_ext)) begin
            rem_eff = ramp_ext[CNT_W-1:0];
        end
        rem_new = rem_eff - ONE;
        // Slow down once the steps left, including the one about to start,
        // fit in ramp+1 periods; the last period then returns to START_PERIOD.
        near_end = ({1'b0, rem_new} <= ramp_ext);

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    dir_d        = DIR_in;
                    remaining_d  = STEPS;
                    step_cnt_d   = '0;
                    busy_d       = 1'b1;
                    period_cnt_d = '0;
                    cur_period_d = START_P;
                    ramp_d       = '0;
                    state_d      = (STEPS != '0) ? S_ACCEL : S_FIN;
                end
            end

            S_ACCEL, S_CRUISE, S_DECEL: begin
                remaining_d = rem_eff;
                if (period_end) begin
                    step_cnt_d   = step_cnt_q + ONE;
                    remaining_d  = rem_new;
                    period_cnt_d = '0;
                    if (rem_new == '0) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (state_q == S_ACCEL) begin
                        if (near_end) begin
                            state_d = S_DECEL;
                        end else begin
                            cur_period_d = faster_period;
                            ramp_d       = ramp_q + ONE;
                            if (faster_period == MIN_P) state_d = S_CRUISE;
                        end
                    end else if (state_q == S_CRUISE) begin
                        if (near_end) state_d = S_DECEL;
                    end else begin
                        cur_period_d = (cur_period_q > ADD_CEIL) ? START_P
                                                                 : cur_period_q + DEC_P;
                        ramp_d       = (ramp_q == '0) ? '0 : ramp_q - ONE;
                    end
                end else begin
                    period_cnt_d = period_cnt_q + ONE;
                end
            end

            S_FIN: begin
                // A zero-step move arrives here with BUSY still high and no
                // DONE yet; it spends one extra cycle to raise DONE.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // PWM is registered but aligned with period_cnt, so the first pulse
        // is already high in the cycle after START is accepted.
        run_d = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
        pwm_d = run_d && (period_cnt_d < PULSE_P);
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples the values computed before this edge.
        if (RST) begin
            state_q      <= S_IDLE;
            period_cnt_q <= '0;
            cur_period_q <= START_P;
            ramp_q       <= '0;
            remaining_q  <= '0;
            step_cnt_q   <= '0;
            pwm_q        <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            cur_period_q <= cur_period_d;
            ramp_q       <= ramp_d;
            remaining_q  <= remaining_d;
            step_cnt_q   <= step_cnt_d;
            pwm_q        <= pwm_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign PWM      = pwm_q;
    assign DIR_out  = dir_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_step_ramp_gen.sv
// -----------------------------------------------------------------------------
// tb_step_ramp_gen
//   Drives move commands into step_ramp_gen and compares the observed pulse
//   train against a step-level profile model. The DUT runs with periods scaled
//   down by ten (100/20/2) so the ramp still spans 40 period changes, as with
//   the default 1000/200/20, while long moves stay short in simulated time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_ramp_gen;

    localparam int CNT_W   = 16;
    localparam int T_START = 100;
    localparam int T_MIN   = 20;
    localparam int T_DEC   = 2;
    localparam int T_PW    = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             DIR_in;
    logic [CNT_W-1:0] STEPS;
`ifdef STEP_ABORT_EN
    logic             ABORT;
`endif
    logic             PWM;
    logic             DIR_out;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] STEP_CNT;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 CLK = ~CLK;

    step_ramp_gen #(
        .CNT_W       (CNT_W),
        .START_PERIOD(T_START),
        .MIN_PERIOD  (T_MIN),
        .ACCEL_DEC   (T_DEC),
        .PULSE_W     (T_PW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .DIR_in  (DIR_in),
        .STEPS   (STEPS),
`ifdef STEP_ABORT_EN
        .ABORT   (ABORT),
`endif
        .PWM     (PWM),
        .DIR_out (DIR_out),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .STEP_CNT(STEP_CNT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Step-by-step period list for an n-step move: speed up by T_DEC per step
    // until T_MIN, hold, and start slowing once the steps left fit in the
    // ramp built so far plus one; slowing mirrors the speed-up.
    function automatic void build_profile(input int n);
        int per;
        int ramp;
        int left;
        bit at_speed;
        bit slowing;
        exp_q.delete();
        per = T_START;
        ramp = 0;
        at_speed = 0;
        slowing = 0;
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back(per);
            left = n - k;
            if (left > 0) begin
                if (slowing) begin
                    per  = (per + T_DEC > T_START) ? T_START : per + T_DEC;
                    ramp = (ramp > 0) ? ramp - 1 : 0;
                end else if (left <= ramp + 1) begin
                    slowing = 1;
                end else if (!at_speed) begin
                    per  = (per - T_DEC < T_MIN) ? T_MIN : per - T_DEC;
                    ramp = ramp + 1;
                    if (per == T_MIN) at_speed = 1;
                end
            end
        end
    endfunction

    // Issues one move and checks it until DONE (cycle 1 = first cycle after
    // the accepting edge). Optionally pokes START mid-move, or holds START
    // high during the DONE cycle to check it is only taken one cycle later.
    task automatic run_move(input int n, input logic dir, input bit poke, input bit start_at_done);
        int rises[$];
        int widths[$];
        int sum, budget, cyc, done_cyc, poke_cyc, end_cyc;
        int busy_bad, cnt_bad, dir_bad, width_bad;
        logic prev_pwm;
        bit done_seen;

        build_profile(n);
        sum = 0;
        foreach (exp_q[i]) sum += exp_q[i];
        budget   = sum + 20;
        poke_cyc = (poke && n > 0) ? int'($urandom_range(2, 40)) : -1;

        START  = 1'b1;
        STEPS  = CNT_W'(n);
        DIR_in = dir;
        @(negedge CLK);

        cyc = 1; done_cyc = 0; done_seen = 0; prev_pwm = 1'b0;
        busy_bad = 0; cnt_bad = 0; dir_bad = 0; width_bad = 0;
        while (!done_seen && cyc <= budget) begin
            if (PWM === 1'b1 && prev_pwm !== 1'b1) begin
                rises.push_back(cyc);
                widths.push_back(0);
            end
            if (PWM === 1'b1 && widths.size() > 0) widths[widths.size()-1] = widths[widths.size()-1] + 1;
            if (DONE === 1'b1) begin
                done_seen = 1;
                done_cyc  = cyc;
            end else begin
                if (BUSY !== 1'b1) busy_bad++;
                if (STEP_CNT !== CNT_W'((n == 0) ? 0 : rises.size() - 1)) cnt_bad++;
            end
            if (DIR_out !== dir) dir_bad++;
            prev_pwm = PWM;
            START  = (cyc == poke_cyc);
            DIR_in = ~dir;
            if (cyc == poke_cyc) STEPS = CNT_W'($urandom);
            if (!done_seen) begin
                @(negedge CLK);
                cyc++;
            end
        end

        check("done_seen", done_seen, 1);
        check("done_cycle", done_cyc, (n == 0) ? 2 : sum + 1);
        check("busy_at_done", BUSY, 0);
        check("pwm_at_done", PWM, 0);
        check("step_cnt_at_done", STEP_CNT, n);
        check("pulse_count", rises.size(), n);
        check("busy_during_move", busy_bad, 0);
        check("step_cnt_tracking", cnt_bad, 0);
        check("dir_stable", dir_bad, 0);
        if (n > 0 && rises.size() > 0) check("first_rise_cycle", rises[0], 1);
        for (int i = 0; i < rises.size() && i < n; i++) begin
            end_cyc = (i + 1 < rises.size()) ? rises[i+1] : done_cyc;
            check($sformatf("n%0d_period[%0d]", n, i + 1), end_cyc - rises[i], exp_q[i]);
            if (widths[i] != T_PW) width_bad++;
        end
        check("pulse_width", width_bad, 0);

        if (start_at_done) begin
            START  = 1'b1;
            STEPS  = '0;
            DIR_in = 1'b0;
        end else begin
            START = 1'b0;
        end
        @(negedge CLK);
        check("done_one_cycle", DONE, 0);
        check("busy_after_done", BUSY, 0);
        check("step_cnt_hold", STEP_CNT, n);
        if (start_at_done) begin
            @(negedge CLK);
            START = 1'b0;
            check("start_after_done_taken", BUSY, 1);
            check("step_cnt_cleared", STEP_CNT, 0);
            @(negedge CLK);
            check("zero_move_done", DONE, 1);
            @(negedge CLK);
        end
    endtask

    initial begin
        int cyc;
        int pwm_hits;
        int done_hits;

        RST    = 1'b1;
        START  = 1'b0;
        STEPS  = '0;
        DIR_in = 1'b0;
`ifdef STEP_ABORT_EN
        ABORT  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_pwm", PWM, 0);
        check("rst_dir", DIR_out, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_step_cnt", STEP_CNT, 0);
        RST = 1'b0;
        @(negedge CLK);

        run_move(1, 1'b1, 1'b0, 1'b0);      // single pulse, one full start period
        run_move(0, 1'b0, 1'b0, 1'b0);      // zero steps: no pulse, DONE one cycle later
        run_move(200, 1'b1, 1'b1, 1'b0);    // full trapezoid with cruise, START poked mid-move
        run_move(10, 1'b0, 1'b0, 1'b0);     // triangular profile
        run_move(3, 1'b1, 1'b0, 1'b1);      // START during DONE is taken the next cycle

        for (int m = 0; m < 5; m++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            run_move(int'($urandom_range(0, 90)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a long move: outputs clear, no DONE follows.
        START  = 1'b1;
        STEPS  = CNT_W'(200);
        DIR_in = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (STEP_CNT !== CNT_W'(50) && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
        end
        check("reach_step_50", STEP_CNT, 50);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_pwm", PWM, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_step_cnt", STEP_CNT, 0);
        check("midrst_done", DONE, 0);
        check("midrst_dir", DIR_out, 0);
        RST = 1'b0;
        pwm_hits = 0;
        done_hits = 0;
        repeat (300) begin
            @(negedge CLK);
            if (PWM !== 1'b0) pwm_hits++;
            if (DONE !== 1'b0) done_hits++;
        end
        check("no_pwm_after_reset", pwm_hits, 0);
        check("no_done_after_reset", done_hits, 0);

        run_move(5, 1'b0, 1'b0, 1'b0);      // clean move after the mid-move reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
